// File: rtl/uart_rx_deser_cfg_pkg.sv
// Shared definitions for the UART RX deserializer: FSM state encoding and default frame width.
package uart_rx_deser_cfg_pkg;

  // Default maximum frame width in bits.
  localparam int unsigned DefaultDataWidth = 8;

  // Deserializer states. SHIFT accepts bits, FULL holds a completed frame until the next clear.
  typedef enum logic {
    StShift = 1'b0,
    StFull  = 1'b1
  } deser_state_e;

endpackage

// File: rtl/uart_rx_deser_cfg.sv
// UART RX deserializer with runtime frame width, LSB/MSB-first ordering, frame-done strobe and
// sticky overrun flag. P_DATA holds the last complete frame while the next one shifts in.
// Optional build macro UART_DESER_PARITY_EN adds par_odd input and par_calc output.
module uart_rx_deser_cfg
  import uart_rx_deser_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_clr,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic                  cfg_msb_first,
`ifdef UART_DESER_PARITY_EN
  input  logic                  par_odd,
  output logic                  par_calc,
`endif
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  frame_done,
  output logic                  deser_full,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  bit_count
);

  localparam logic [CNT_WIDTH-1:0] MaxWidth = CNT_WIDTH'(DATA_WIDTH);

  deser_state_e            state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   pdata_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [CNT_WIDTH-1:0]    width_q;
  logic                    msb_q;
  logic                    done_q;
  logic                    ovr_q;

  // Effective view of the frame context this cycle: a clear takes effect before the capture.
  deser_state_e            state_eff;
  logic [DATA_WIDTH-1:0]   shreg_eff;
  logic [CNT_WIDTH-1:0]    count_eff;
  logic [CNT_WIDTH-1:0]    width_eff;
  logic                    msb_eff;
  logic [CNT_WIDTH-1:0]    idx;
  logic [DATA_WIDTH-1:0]   shreg_cap;
  logic [DATA_WIDTH-1:0]   width_mask;
  logic                    last_bit;

`ifdef UART_DESER_PARITY_EN
  logic                    par_odd_q;
  logic                    par_odd_eff;
  logic                    par_q;
`endif

  // Resolve clear-vs-latched context, bit index, captured shift value and width mask.
  always_comb begin
    state_eff = deser_clr ? StShift : state_q;
    shreg_eff = deser_clr ? '0 : shreg_q;
    count_eff = deser_clr ? '0 : count_q;
    msb_eff   = deser_clr ? cfg_msb_first : msb_q;
    if (deser_clr) begin
      width_eff = ((cfg_width == '0) || (cfg_width > MaxWidth)) ? MaxWidth : cfg_width;
    end else begin
      width_eff = width_q;
    end
    idx       = msb_eff ? (width_eff - count_eff - CNT_WIDTH'(1)) : count_eff;
    shreg_cap = shreg_eff | (DATA_WIDTH'(sampled_bit) << idx);
    last_bit  = (count_eff == (width_eff - CNT_WIDTH'(1)));
    width_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      width_mask[i] = (i < 32'(width_eff));
    end
  end

`ifdef UART_DESER_PARITY_EN
  // Parity polarity follows the same clear-then-capture rule as the frame config.
  always_comb begin
    par_odd_eff = deser_clr ? par_odd : par_odd_q;
  end
`endif

  // Deserializer FSM with registered outputs; later assignments override the clear defaults.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StShift;
      shreg_q   <= '0;
      pdata_q   <= '0;
      count_q   <= '0;
      width_q   <= MaxWidth;
      msb_q     <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_DESER_PARITY_EN
      par_odd_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (deser_clr) begin
        state_q   <= StShift;
        shreg_q   <= '0;
        count_q   <= '0;
        ovr_q     <= 1'b0;
        width_q   <= width_eff;
        msb_q     <= msb_eff;
`ifdef UART_DESER_PARITY_EN
        par_odd_q <= par_odd_eff;
`endif
      end
      if (deser_en) begin
        if (state_eff == StShift) begin
          shreg_q <= shreg_cap;
          count_q <= count_eff + CNT_WIDTH'(1);
          if (last_bit) begin
            pdata_q <= shreg_cap & width_mask;
            done_q  <= 1'b1;
            state_q <= StFull;
`ifdef UART_DESER_PARITY_EN
            par_q   <= (^(shreg_cap & width_mask)) ^ par_odd_eff;
`endif
          end
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign P_DATA     = pdata_q;
  assign frame_done = done_q;
  assign deser_full = (state_q == StFull);
  assign overrun    = ovr_q;
  assign bit_count  = count_q;
`ifdef UART_DESER_PARITY_EN
  assign par_calc   = par_q;
`endif

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Self-checking bench for uart_rx_deser_cfg: directed scenarios then random traffic, all
// compared against a frame-level model built from a queue of received bits.
module tb_uart_rx_deser_cfg;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          deser_clr = 1'b0;
  logic          deser_en = 1'b0;
  logic          sampled_bit = 1'b0;
  logic [CW-1:0] cfg_width = '0;
  logic          cfg_msb_first = 1'b0;
  logic          par_odd = 1'b0;
  logic          par_calc;
  logic [DW-1:0] P_DATA;
  logic          frame_done;
  logic          deser_full;
  logic          overrun;
  logic [CW-1:0] bit_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            m_q[$];
  int            m_w;
  bit            m_msb;
  bit            m_podd;
  bit            m_full;
  bit            m_ovr;
  bit            m_done;
  logic [DW-1:0] m_pdata;
  bit            m_par;

  uart_rx_deser_cfg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .deser_clr    (deser_clr),
    .deser_en     (deser_en),
    .sampled_bit  (sampled_bit),
    .cfg_width    (cfg_width),
    .cfg_msb_first(cfg_msb_first),
`ifdef UART_DESER_PARITY_EN
    .par_odd      (par_odd),
    .par_calc     (par_calc),
`endif
    .P_DATA       (P_DATA),
    .frame_done   (frame_done),
    .deser_full   (deser_full),
    .overrun      (overrun),
    .bit_count    (bit_count)
  );

`ifndef UART_DESER_PARITY_EN
  assign par_calc = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_w = DW; m_msb = 1'b0; m_podd = 1'b0;
    m_full = 1'b0; m_ovr = 1'b0; m_done = 1'b0; m_pdata = '0; m_par = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pdata"}, 32'(P_DATA), 32'(m_pdata));
    chk({tag, ".done"},  32'(frame_done), 32'(m_done));
    chk({tag, ".full"},  32'(deser_full), 32'(m_full));
    chk({tag, ".ovr"},   32'(overrun), 32'(m_ovr));
    chk({tag, ".count"}, 32'(bit_count), 32'(m_q.size()));
`ifdef UART_DESER_PARITY_EN
    chk({tag, ".par"},   32'(par_calc), 32'(m_par));
`endif
  endtask

  // One clock with the given inputs, then advance the model and compare.
  task automatic step(input bit clr, input bit en, input bit b, input int w, input bit msb,
                      input bit podd, input string tag);
    int ones;
    @(negedge CLK);
    deser_clr = clr; deser_en = en; sampled_bit = b;
    cfg_width = CW'(w); cfg_msb_first = msb; par_odd = podd;
    @(posedge CLK);
    #1;
    deser_clr = 1'b0; deser_en = 1'b0;
    m_done = 1'b0;
    if (clr) begin
      m_q.delete();
      m_full = 1'b0; m_ovr = 1'b0;
      m_w = ((w == 0) || (w > int'(DW))) ? int'(DW) : w;
      m_msb = msb; m_podd = podd;
    end
    if (en) begin
      if (m_full) m_ovr = 1'b1;
      else begin
        m_q.push_back(b);
        if (m_q.size() == m_w) begin
          m_pdata = '0; ones = 0;
          for (int i = 0; i < m_w; i++) begin
            m_pdata[m_msb ? (m_w - 1 - i) : i] = m_q[i];
            ones += int'(m_q[i]);
          end
          m_par = (ones % 2 == 1) ^ m_podd;
          m_full = 1'b1; m_done = 1'b1;
        end
      end
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    bit t1[8];
    bit t2[5];
    t1 = '{1, 0, 1, 1, 0, 0, 1, 0};
    t2 = '{1, 0, 0, 1, 1};
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b1;

    // 1: default config after reset, LSB-first 8 bits
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, t1[i], 0, 1'b0, 1'b0, "t1");
    chk("t1.const", 32'(P_DATA), 32'h4D);
    idle("t1.idle");
    chk("t1.done_low", 32'(frame_done), 32'h0);

    // 2: width 5, MSB-first
    step(1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, "t2.clr");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, t2[i], 0, 1'b0, 1'b0, "t2");
    chk("t2.const", 32'(P_DATA), 32'h13);
    chk("t2.cnt5", 32'(bit_count), 32'd5);

    // 3: overrun while full, cleared by clr
    step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "t3.ovr1");
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "t3.ovr2");
    chk("t3.ovr_const", 32'(overrun), 32'h1);
    step(1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, "t3.clr");
    chk("t3.pdata_held", 32'(P_DATA), 32'h13);

    // 4: clr+en same cycle, then cfg changes mid-frame are ignored
    step(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, "t4.clren");
    chk("t4.cnt1", 32'(bit_count), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'(i), 3, 1'b1, 1'b1, "t4");

    // 5: reset mid-frame, then cfg_width=0 means full width
    step(1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0, "t5.clr");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "t5.part");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    model_reset();
    check_all("t5.rst");
    @(negedge CLK);
    RST = 1'b1;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "t5.w0");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, t1[i], 0, 1'b0, 1'b1, "t5.w0f");
    chk("t5.w0_const", 32'(P_DATA), 32'h4D);

    // 1-bit frames complete on each clr+en
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'(i), 1, 1'(i >> 1), 1'b0, "w1");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
